// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared helpers for the DPRAM FIFO controller.
//   addr_width : RAM address width for a given depth (never less than 1)
//   ptr_full   : full test on wrap-bit pointers (low bits equal, MSB differs)
//   ptr_empty  : empty test on wrap-bit pointers (pointers identical)
// Pointers are handed in zero-extended to PTR_MAX_W bits so one function
// serves any depth; aw tells the function where the wrap bit sits.
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int PTR_MAX_W = 32;

  // A depth of 1 would give $clog2 == 0, which is not a usable port width.
  function automatic int addr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Same slot but one lap apart means the writer has lapped the reader.
  function automatic logic ptr_full(input logic [PTR_MAX_W-1:0] wp,
                                    input logic [PTR_MAX_W-1:0] rp,
                                    input int aw);
    logic [PTR_MAX_W-1:0] diff;
    logic [PTR_MAX_W-1:0] low_mask;
    diff     = wp ^ rp;
    low_mask = (32'd1 << aw) - 32'd1;
    return diff[aw] && ((diff & low_mask) == '0);
  endfunction

  // Same slot and same lap means nothing is stored.
  function automatic logic ptr_empty(input logic [PTR_MAX_W-1:0] wp,
                                     input logic [PTR_MAX_W-1:0] rp);
    return wp == rp;
  endfunction

endpackage

// File: rtl/dpram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// dpram_fifo_ctrl
// Single-clock FIFO controller for an external true dual-port RAM. Port A is
// the write port, port B the read port (its write enable is held low). The
// controller keeps pointers, occupancy and status/error flags; the data
// lives in the RAM.
// Ports:
//   clk, rst_n          clock (also feeds both RAM clocks), async active-low reset
//   push, din, full     producer side; push is accepted only when not full
//   almost_full         count >= AF_LEVEL
//   pop, empty          consumer side; pop is accepted only when not empty
//   dout, rd_valid      read data straight from ram_doutb, valid one cycle
//                       after an accepted pop
//   almost_empty        count <= AE_LEVEL
//   count               occupancy 0..DEPTH
//   overflow/underflow  sticky: push while full / pop while empty
//   ram_*               RAM port A (write) and port B (read) drive
// ---------------------------------------------------------------------------
module dpram_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  localparam int AW      = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             almost_full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             rd_valid,
  output logic             empty,
  output logic             almost_empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow,
  output logic             ram_ena,
  output logic             ram_wea,
  output logic [AW-1:0]    ram_addra,
  output logic [WIDTH-1:0] ram_dina,
  output logic             ram_enb,
  output logic             ram_web,
  output logic [AW-1:0]    ram_addrb,
  input  logic [WIDTH-1:0] ram_doutb
);

  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF_THR = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_THR = PW'(AE_LEVEL);

  logic [PW-1:0] wptr, rptr;
  logic [PW-1:0] wptr_nxt, rptr_nxt;
  logic          wr_ok, rd_ok;

  // Requests are judged against the registered flags, so a push and a pop in
  // the same cycle each see the state from the start of that cycle.
  assign wr_ok = push & ~full;
  assign rd_ok = pop  & ~empty;

  assign wptr_nxt = wptr + {{AW{1'b0}}, wr_ok};
  assign rptr_nxt = rptr + {{AW{1'b0}}, rd_ok};

  // RAM drive: rejected operations leave both ports idle.
  assign ram_ena   = wr_ok;
  assign ram_wea   = wr_ok;
  assign ram_addra = wptr[AW-1:0];
  assign ram_dina  = din;
  assign ram_enb   = rd_ok;
  assign ram_web   = 1'b0;
  assign ram_addrb = rptr[AW-1:0];

  // The RAM output register already provides the one-cycle read latency.
  assign dout = ram_doutb;

  // Modular subtraction of the wrap-bit pointers gives 0..DEPTH directly.
  assign count        = wptr - rptr;
  assign almost_full  = (count >= AF_THR);
  assign almost_empty = (count <= AE_THR);

  // Pointer and flag registers. empty/full are computed from the next-state
  // pointers so they line up with the pointers they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wptr     <= wptr_nxt;
      rptr     <= rptr_nxt;
      empty    <= ptr_empty(PTR_MAX_W'(wptr_nxt), PTR_MAX_W'(rptr_nxt));
      full     <= ptr_full(PTR_MAX_W'(wptr_nxt), PTR_MAX_W'(rptr_nxt), AW);
      rd_valid <= rd_ok;
      if (push && full)
        overflow <= 1'b1;
      if (pop && empty)
        underflow <= 1'b1;
    end
  end

endmodule

// File: doc/dpram_fifo_ctrl.md
Name: dpram_fifo_ctrl

Overview:
Single-clock FIFO controller that drives an external true dual-port RAM (DPRAM, WIDTH x DEPTH). RAM port A is used as the write port and port B as the read port; port B's write enable is tied low.
- Upstream: a producer using the push/full handshake.
- Downstream: a consumer using the pop/empty handshake, with read data qualified by rd_valid.
- The block owns pointers, occupancy, status flags and error flags. It stores no data.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 4, number of RAM entries; must be a power of 2 and >= 2
AW, $clog2(DEPTH), RAM address width (localparam, not overridable)
AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL

Ports:
clk  input  1  single clock; also drives both RAM clocks (clka and clkb)
rst_n  input  1  asynchronous active-low reset
push  input  1  write request
din  input  WIDTH  write data
full  output  1  FIFO full
almost_full  output  1  count >= AF_LEVEL
pop  input  1  read request
dout  output  WIDTH  read data; equals ram_doutb
rd_valid  output  1  dout valid, one cycle after an accepted pop
empty  output  1  FIFO empty
almost_empty  output  1  count <= AE_LEVEL
count  output  AW+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a push was attempted while full
underflow  output  1  sticky: a pop was attempted while empty
ram_ena  output  1  RAM port A enable
ram_wea  output  1  RAM port A write enable
ram_addra  output  AW  RAM port A address
ram_dina  output  WIDTH  RAM port A write data
ram_enb  output  1  RAM port B enable
ram_web  output  1  RAM port B write enable; constant 0
ram_addrb  output  AW  RAM port B address
ram_doutb  input  WIDTH  RAM port B read data; registered, 1-cycle latency

Behaviour:
- Acceptance conditions (combinational):
  - wr_ok = push & ~full
  - rd_ok = pop & ~empty
- RAM drive (combinational):
  - ram_ena = ram_wea = wr_ok; ram_addra = wptr[AW-1:0]; ram_dina = din.
  - ram_enb = rd_ok; ram_addrb = rptr[AW-1:0]; ram_web = 0.
- Pointers:
  - wptr and rptr are AW+1 bits wide.
  - On wr_ok, wptr increments; on rd_ok, rptr increments.
  - Both wrap naturally modulo 2*DEPTH.
- Flags, registered and derived from the next-state pointers:
  - empty = (wptr == rptr).
  - full = (low AW bits equal) & (MSBs differ).
- count = wptr - rptr, modulo 2^(AW+1). almost_full and almost_empty are compared against count.
- rd_valid is a register: rd_valid <= rd_ok. dout passes ram_doutb through unchanged. Read latency is 1 cycle from the accepted pop edge.
- Simultaneous push and pop:
  - Each is judged against the flags at the start of the cycle.
  - When full: the pop is accepted and the push is rejected (overflow sets). Next cycle count = DEPTH-1.
  - When empty: the push is accepted and the pop is rejected (underflow sets). The written data is not readable until the next cycle.
  - Otherwise both are accepted and count is unchanged.
  - Same-address read/write cannot occur while neither flag is set, because the pointers differ.
- Error flags: overflow sets on push & full; underflow sets on pop & empty. Both are sticky until reset. Rejected operations do not move pointers or touch the RAM.
- Reset (asynchronous on rst_n falling, released synchronously to clk):
  - wptr = rptr = 0; count = 0.
  - empty = 1, almost_empty = 1 (since count 0 <= AE_LEVEL).
  - full = 0, almost_full = 0.
  - rd_valid = 0, overflow = 0, underflow = 0.
  - RAM enables deassert. RAM contents are not cleared.
  - Reset mid-read drops a pending rd_valid.
- There is no state machine. State is the pointers, rd_valid and the sticky flags.

Decomposition:
- Package fifo_pkg holds:
  - function ptr_full(wptr, rptr)
  - function ptr_empty(wptr, rptr)
  - a shared clog2-based AW helper
- No sub-module in the controller itself.
- Bench top instantiates dpram_fifo_ctrl together with DPRAM, connecting clka = clkb = clk.

Test Plan (all with WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1):
- Reset release, no activity -> empty=1, full=0, count=0, almost_empty=1, rd_valid=0, all RAM enables 0.
- Push 0xA0, 0xA1, 0xA2, 0xA3 on consecutive cycles:
  - ram_addra steps 0,1,2,3.
  - almost_full rises after the 3rd push; full=1 and count=4 after the 4th.
  - A 5th push of 0xA4 sets overflow, leaves count=4 and keeps ram_wea=0.
- Then pop four times -> dout = 0xA0, 0xA1, 0xA2, 0xA3 with rd_valid one cycle after each pop; empty=1 after the 4th. A 5th pop sets underflow and rd_valid stays 0.
- Wrap-around: push and pop streaming 10 words 0x10..0x19 with count held at 1..2 -> addresses wrap 3->0, output order is preserved, and no flags set.
- Simultaneous push+pop:
  - When full -> pop accepted, push rejected (overflow=1), count goes 4->3.
  - When empty with push 0x55 -> pop rejected (underflow=1), count goes 0->1, and the next pop returns 0x55.
- Assert rst_n low between cycles, mid-stream with count=2 and a pop in flight -> immediately count=0, empty=1 and rd_valid=0; a post-reset push/pop returns fresh data from address 0.
